// File: rtl/def_pkg.sv
// Shared types and constants for the def_out packet filter: FSM states and
// the location of the byte-length field inside tuser.
package def_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 15;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream master slot; loads a beat when told to,
// holds under backpressure and drops valid once the beat is accepted.
module axis_out_reg #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [USER_W-1:0] user,
  input  logic [DATA_W/8-1:0] keep,
  input  logic              last,
  input  logic              ready,
  output logic [DATA_W-1:0] reg_data,
  output logic [USER_W-1:0] reg_user,
  output logic [DATA_W/8-1:0] reg_keep,
  output logic              reg_last,
  output logic              valid,
  output logic              free
);

  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      reg_data <= '0;
      reg_user <= '0;
      reg_keep <= '0;
      reg_last <= 1'b0;
      valid    <= 1'b0;
    end else if (load) begin
      reg_data <= data;
      reg_user <= user;
      reg_keep <= keep;
      reg_last <= last;
      valid    <= 1'b1;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/def_out.sv
// Packet forwarder with an optional short-packet filter between a fall-through
// FIFO and a registered AXI-Stream master; counts forwarded and dropped packets.
module def_out
  import def_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int MIN_PKT_LEN          = 64
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic                              i_pkt_fifo_empty,
  output logic                              o_pkt_fifo_rd_en,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    i_tdata_fifo,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   i_tuser_fifo,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  i_tkeep_fifo,
  input  logic                              i_tlast_fifo,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic                              i_drop_en,
  output logic [31:0]                       o_pkt_cnt,
  output logic [31:0]                       o_drop_cnt
);

  state_t           state;
  logic             head;
  logic             drop_head;
  logic             slot_free;
  logic             load;
  logic [LEN_W-1:0] len;

  assign head      = !i_pkt_fifo_empty;
  assign len       = i_tuser_fifo[LEN_MSB:LEN_LSB];
  assign drop_head = i_drop_en && (len < LEN_W'(MIN_PKT_LEN));

  // Dropped beats are popped regardless of the output slot; only forwarded
  // beats wait for space.
  always_comb begin
    o_pkt_fifo_rd_en = 1'b0;
    load             = 1'b0;
    if (axis_resetn && head) begin
      case (state)
        ST_IDLE: begin
          o_pkt_fifo_rd_en = drop_head || slot_free;
          load             = !drop_head && slot_free;
        end
        ST_PASS: begin
          o_pkt_fifo_rd_en = slot_free;
          load             = slot_free;
        end
        ST_DROP: o_pkt_fifo_rd_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state      <= ST_IDLE;
      o_pkt_cnt  <= '0;
      o_drop_cnt <= '0;
    end else if (o_pkt_fifo_rd_en) begin
      case (state)
        ST_IDLE: begin
          if (i_tlast_fifo) begin
            if (drop_head) o_drop_cnt <= o_drop_cnt + 32'd1;
            else           o_pkt_cnt  <= o_pkt_cnt + 32'd1;
          end else begin
            state <= drop_head ? ST_DROP : ST_PASS;
          end
        end
        ST_PASS: if (i_tlast_fifo) begin
          state     <= ST_IDLE;
          o_pkt_cnt <= o_pkt_cnt + 32'd1;
        end
        ST_DROP: if (i_tlast_fifo) begin
          state      <= ST_IDLE;
          o_drop_cnt <= o_drop_cnt + 32'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_W(C_M_AXIS_DATA_WIDTH),
    .USER_W(C_M_AXIS_TUSER_WIDTH)
  ) u_out (
    .clk     (axis_aclk),
    .resetn  (axis_resetn),
    .load    (load),
    .data    (i_tdata_fifo),
    .user    (i_tuser_fifo),
    .keep    (i_tkeep_fifo),
    .last    (i_tlast_fifo),
    .ready   (m_axis_tready),
    .reg_data(m_axis_tdata),
    .reg_user(m_axis_tuser),
    .reg_keep(m_axis_tkeep),
    .reg_last(m_axis_tlast),
    .valid   (m_axis_tvalid),
    .free    (slot_free)
  );

endmodule

// File: tb/tb_def_out.sv
// Directed bench for def_out: forwarding, backpressure, short-packet drop,
// back-to-back packets, mid-packet reset and counter wrap.
module tb_def_out;
  import def_pkg::*;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          rd_en;
  logic [DW-1:0] tdata_in = '0;
  logic [UW-1:0] tuser_in = '0;
  logic [KW-1:0] tkeep_in = '0;
  logic          tlast_in = 1'b0;
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          drop_en = 1'b0;
  logic [31:0]   pkt_cnt;
  logic [31:0]   drop_cnt;

  int compared   = 0;
  int mismatched = 0;

  def_out #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .MIN_PKT_LEN         (64)
  ) dut (
    .axis_aclk       (clk),
    .axis_resetn     (resetn),
    .i_pkt_fifo_empty(fifo_empty),
    .o_pkt_fifo_rd_en(rd_en),
    .i_tdata_fifo    (tdata_in),
    .i_tuser_fifo    (tuser_in),
    .i_tkeep_fifo    (tkeep_in),
    .i_tlast_fifo    (tlast_in),
    .m_axis_tdata    (tdata),
    .m_axis_tuser    (tuser),
    .m_axis_tkeep    (tkeep),
    .m_axis_tlast    (tlast),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (tready),
    .i_drop_en       (drop_en),
    .o_pkt_cnt       (pkt_cnt),
    .o_drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", compared);
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] val, input logic [15:0] len, input logic last);
    fifo_empty = 1'b0;
    tdata_in   = DW'(val);
    tuser_in   = UW'(len);
    tkeep_in   = '1;
    tlast_in   = last;
  endtask

  task automatic no_data;
    fifo_empty = 1'b1;
    tlast_in   = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    present(32'hdead, 16'd128, 1'b1);
    #1;
    compared++;
    if (rd_en !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_rd_en got %0b want 0", rd_en);
    end
    step;
    step;
    compared++;
    if (tvalid !== 1'b0 || tdata !== '0 || tuser !== '0 || tkeep !== '0 || tlast !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs got valid=%0b last=%0b keep=%h want all zero", tvalid, tlast, tkeep);
    end
    compared++;
    if (pkt_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_counters got pkt=%0d drop=%0d want 0/0", pkt_cnt, drop_cnt);
    end
    no_data;
    resetn = 1'b1;
    step;
  endtask

  task automatic test_basic;
    tready  = 1'b1;
    drop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(32'h100 + 32'(i), 16'd128, i == 2);
      #1;
      compared++;
      if (rd_en !== 1'b1) begin
        mismatched++;
        $display("FAIL basic_pop%0d got %0b want 1", i, rd_en);
      end
      step;
      compared++;
      if (tvalid !== 1'b1 || tdata !== DW'(32'h100 + 32'(i)) || tlast !== (i == 2)) begin
        mismatched++;
        $display("FAIL basic_beat%0d got valid=%0b data=%0h last=%0b want 1/%0h/%0b",
                 i, tvalid, tdata[31:0], tlast, 32'h100 + 32'(i), i == 2);
      end
    end
    compared++;
    if (tuser !== UW'(16'd128) || tkeep !== {KW{1'b1}}) begin
      mismatched++;
      $display("FAIL basic_side got user=%0h keep=%h want 80/all ones", tuser[15:0], tkeep);
    end
    no_data;
    step;
    compared++;
    if (tvalid !== 1'b0 || pkt_cnt !== 32'd1) begin
      mismatched++;
      $display("FAIL basic_end got valid=%0b pkt=%0d want 0/1", tvalid, pkt_cnt);
    end
  endtask

  task automatic test_backpressure;
    present(32'h201, 16'd128, 1'b0);
    step;
    compared++;
    if (tvalid !== 1'b1 || tdata !== DW'(32'h201)) begin
      mismatched++;
      $display("FAIL bp_beat1 got valid=%0b data=%0h want 1/201", tvalid, tdata[31:0]);
    end
    tready = 1'b0;
    present(32'h202, 16'd128, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++;
      if (rd_en !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_stall_pop%0d got %0b want 0", i, rd_en);
      end
      step;
      compared++;
      if (tvalid !== 1'b1 || tdata !== DW'(32'h201) || tlast !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold%0d got valid=%0b data=%0h want 1/201", i, tvalid, tdata[31:0]);
      end
    end
    tready = 1'b1;
    #1;
    compared++;
    if (rd_en !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_resume_pop got %0b want 1", rd_en);
    end
    step;
    compared++;
    if (tvalid !== 1'b1 || tdata !== DW'(32'h202)) begin
      mismatched++;
      $display("FAIL bp_beat2 got valid=%0b data=%0h want 1/202", tvalid, tdata[31:0]);
    end
    present(32'h203, 16'd128, 1'b1);
    step;
    compared++;
    if (tvalid !== 1'b1 || tdata !== DW'(32'h203) || tlast !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_beat3 got valid=%0b data=%0h last=%0b want 1/203/1", tvalid, tdata[31:0], tlast);
    end
    no_data;
    step;
    compared++;
    if (pkt_cnt !== 32'd2) begin
      mismatched++;
      $display("FAIL bp_pkt_cnt got %0d want 2", pkt_cnt);
    end
  endtask

  task automatic test_drop;
    drop_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      present(32'h300 + 32'(i), 16'd40, i == 1);
      #1;
      compared++;
      if (rd_en !== 1'b1) begin
        mismatched++;
        $display("FAIL drop_pop%0d got %0b want 1", i, rd_en);
      end
      step;
      compared++;
      if (tvalid !== 1'b0) begin
        mismatched++;
        $display("FAIL drop_valid%0d got %0b want 0", i, tvalid);
      end
    end
    compared++;
    if (drop_cnt !== 32'd1 || pkt_cnt !== 32'd2) begin
      mismatched++;
      $display("FAIL drop_counts got drop=%0d pkt=%0d want 1/2", drop_cnt, pkt_cnt);
    end
    present(32'h340, 16'd64, 1'b1);
    step;
    compared++;
    if (tvalid !== 1'b1 || tdata !== DW'(32'h340)) begin
      mismatched++;
      $display("FAIL drop_len64 got valid=%0b data=%0h want 1/340", tvalid, tdata[31:0]);
    end
    no_data;
    drop_en = 1'b0;
    step;
    compared++;
    if (pkt_cnt !== 32'd3 || drop_cnt !== 32'd1) begin
      mismatched++;
      $display("FAIL drop_after got pkt=%0d drop=%0d want 3/1", pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      present(32'h400 + 32'(i), 16'd100, 1'b1);
      #1;
      compared++;
      if (rd_en !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_pop%0d got %0b want 1", i, rd_en);
      end
      step;
      compared++;
      if (tvalid !== 1'b1 || tdata !== DW'(32'h400 + 32'(i)) || tlast !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_beat%0d got valid=%0b data=%0h last=%0b want 1/%0h/1",
                 i, tvalid, tdata[31:0], tlast, 32'h400 + 32'(i));
      end
    end
    no_data;
    step;
    compared++;
    if (pkt_cnt !== 32'd7) begin
      mismatched++;
      $display("FAIL b2b_pkt_cnt got %0d want 7", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid;
    present(32'h500, 16'd128, 1'b0);
    step;
    present(32'h501, 16'd128, 1'b0);
    resetn = 1'b0;
    #1;
    compared++;
    if (rd_en !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_rd_en got %0b want 0", rd_en);
    end
    step;
    compared++;
    if (tvalid !== 1'b0 || pkt_cnt !== 32'd0 || drop_cnt !== 32'd0 || dut.state !== ST_IDLE) begin
      mismatched++;
      $display("FAIL midrst_state got valid=%0b pkt=%0d drop=%0d state=%0d want 0/0/0/0",
               tvalid, pkt_cnt, drop_cnt, dut.state);
    end
    resetn = 1'b1;
    present(32'h510, 16'd128, 1'b1);
    step;
    compared++;
    if (tvalid !== 1'b1 || tdata !== DW'(32'h510) || tlast !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_next got valid=%0b data=%0h want 1/510", tvalid, tdata[31:0]);
    end
    no_data;
    step;
    compared++;
    if (pkt_cnt !== 32'd1) begin
      mismatched++;
      $display("FAIL midrst_pkt_cnt got %0d want 1", pkt_cnt);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.o_pkt_cnt = 32'hFFFF_FFFF;
    step;
    release dut.o_pkt_cnt;
    #1;
    compared++;
    if (pkt_cnt !== 32'hFFFF_FFFF) begin
      mismatched++;
      $display("FAIL wrap_preload got %0h want ffffffff", pkt_cnt);
    end
    present(32'h600, 16'd200, 1'b1);
    step;
    no_data;
    step;
    compared++;
    if (pkt_cnt !== 32'd0) begin
      mismatched++;
      $display("FAIL wrap_cnt got %0h want 0", pkt_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_drop;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/def_out.md
DEF_OUT -- requirements
Module: def_out

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, meaning data bus width in bits.
REQ-002 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, meaning sideband width; tuser[15:0] holds the packet length in bytes.
REQ-003 SHALL have parameter MIN_PKT_LEN, default 64, meaning the minimum legal length in bytes when filtering is enabled.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 axis_aclk  in  1  clock; all logic on its rising edge.
REQ-006 axis_resetn  in  1  synchronous active-low reset.
REQ-007 i_pkt_fifo_empty  in  1  upstream fall-through FIFO empty; data is valid when this is 0.
REQ-008 o_pkt_fifo_rd_en  out  1  pops the upstream FIFO in the same cycle; combinational.
REQ-009 i_tdata_fifo  in  C_M_AXIS_DATA_WIDTH  FIFO head data.
REQ-010 i_tuser_fifo  in  C_M_AXIS_TUSER_WIDTH  FIFO head tuser.
REQ-011 i_tkeep_fifo  in  C_M_AXIS_DATA_WIDTH/8  FIFO head byte enables.
REQ-012 i_tlast_fifo  in  1  FIFO head end-of-packet.
REQ-013 m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid  out  matching widths  registered AXI-Stream master.
REQ-014 m_axis_tready  in  1  downstream ready.
REQ-015 i_drop_en  in  1  enables the short-packet filter; sampled at packet head only.
REQ-016 o_pkt_cnt  out  32  count of forwarded packets.
REQ-017 o_drop_cnt  out  32  count of dropped packets.

Function
REQ-018 An output register slot SHALL be considered free when m_axis_tvalid=0 or m_axis_tready=1.
REQ-019 In PASS and at a forwarded head, o_pkt_fifo_rd_en SHALL equal !i_pkt_fifo_empty && slot free; the popped beat SHALL appear on m_axis_* in the next cycle with m_axis_tvalid=1 (latency 1).
REQ-020 When a beat is not popped and m_axis_tready=1, m_axis_tvalid SHALL clear next cycle; when m_axis_tready=0, all m_axis_* SHALL hold stable.
REQ-021 The FSM SHALL have states IDLE (waiting for a packet head), PASS (forwarding the body) and DROP (discarding the body).
REQ-022 IDLE, head present: drop decision = i_drop_en && (i_tuser_fifo[15:0] < MIN_PKT_LEN).
REQ-023 IDLE, drop=0: pop under REQ-019; on pop -> PASS, or stay in IDLE if i_tlast_fifo=1; o_pkt_cnt increments on the tlast pop.
REQ-024 IDLE, drop=1: pop unconditionally (independent of tready); -> DROP, or stay in IDLE if i_tlast_fifo=1; o_drop_cnt increments on the tlast pop; nothing is written to the output.
REQ-025 PASS: pop under REQ-019; popping tlast -> IDLE and o_pkt_cnt+1.
REQ-026 DROP: o_pkt_fifo_rd_en = !i_pkt_fifo_empty; popping tlast -> IDLE and o_drop_cnt+1; the output slot still drains normally.
REQ-027 Changes to i_drop_en mid-packet SHALL have no effect on the current packet.
REQ-028 FIFO empty in any state: no pop, state held.
REQ-029 Counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 Back-to-back packets SHALL pass with no idle cycle (tlast and the next head on consecutive cycles).
REQ-031 o_pkt_fifo_rd_en SHALL never assert while i_pkt_fifo_empty=1.

Reset
REQ-032 Reset SHALL set: state IDLE, all m_axis_* = 0, o_pkt_cnt = 0, o_drop_cnt = 0.
REQ-033 o_pkt_fifo_rd_en SHALL be 0 during reset.
REQ-034 A mid-packet reset SHALL abandon the packet; the upstream FIFO is cleared by the same reset.

Structure
REQ-035 FSM state encodings (IDLE, PASS, DROP) and the tuser length-field position constants SHALL reside in a shared package, def_pkg.
REQ-036 The output register slot SHALL be a sub-module, axis_out_reg (data, user, keep, last, valid, ready).
REQ-037 The block SHALL be one clock domain with no internal FIFO.

Verification
REQ-038 Bench: 3-beat packet, len=128, tready=1 -> 3 beats out, each 1 cycle after its pop; o_pkt_cnt=1.
REQ-039 Bench: same packet with tready held 0 for 5 cycles after beat 1 -> beat 1 held stable, no pops for 5 cycles, then beats 2 and 3 out.
REQ-040 Bench: i_drop_en=1, 2-beat packet len=40 -> 2 consecutive pops, m_axis_tvalid stays 0, o_drop_cnt=1; a following len=64 packet is forwarded.
REQ-041 Bench: single-beat packets back-to-back x4, tready=1 -> 4 consecutive output beats each with tlast=1; o_pkt_cnt=4.
REQ-042 Bench: reset asserted mid-PASS -> next cycle m_axis_tvalid=0, state IDLE, counters 0; the next packet forwards cleanly.
REQ-043 Bench: o_pkt_cnt preloaded (force) to 0xFFFFFFFF, one packet forwarded -> o_pkt_cnt=0.
